// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: parses E0/F0 prefixed byte streams
// into key events buffered in a show-ahead FIFO.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int AW          = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_tick,
  input  logic       byte_ok,
  output logic       rx_en,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       evt_valid,
  input  logic       evt_pop,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    S_E0,
    S_F0,
    S_E0F0
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          good;
  logic          bad;
  logic          is_e0;
  logic          is_f0;
  logic          push;
  logic [9:0]    push_ent;

  assign good    = byte_tick && byte_ok;
  assign bad     = byte_tick && !byte_ok;
  assign is_e0   = byte_in == 8'hE0;
  assign is_f0   = byte_in == 8'hF0;
  assign tmo_hit = (state != IDLE) &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // push_ent = {brk, ext, code}
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    push_ent = {2'b00, byte_in};
    if (bad) begin
      state_nx = IDLE;
    end else if (good) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_e0:   state_nx = S_E0;
            is_f0:   state_nx = S_F0;
            default: push = 1'b1;
          endcase
        end
        S_E0: begin
          unique case (1'b1)
            is_f0: state_nx = S_E0F0;
            is_e0: state_nx = S_E0;
            default: begin
              push     = 1'b1;
              push_ent = {2'b01, byte_in};
              state_nx = IDLE;
            end
          endcase
        end
        S_F0: begin
          state_nx = IDLE;
          if (!is_e0 && !is_f0) begin
            push     = 1'b1;
            push_ent = {2'b10, byte_in};
          end
        end
        S_E0F0: begin
          state_nx = IDLE;
          if (!is_e0 && !is_f0) begin
            push     = 1'b1;
            push_ent = {2'b11, byte_in};
          end
        end
      endcase
    end else if (tmo_hit) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      tmo_cnt <= '0;
    else if (byte_tick || state == IDLE || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nx;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nx;
  logic [9:0]    head;
  logic          full;
  logic          pop_do;
  logic          push_do;

  assign full    = cnt == FULL_CNT;
  assign pop_do  = evt_pop && (cnt != '0);
  assign push_do = push && (!full || pop_do);

  always_comb begin
    cnt_nx = cnt;
    rd_nx  = rd_ptr;
    if (pop_do) rd_nx = rd_ptr + AW'(1);
    if (push_do && !pop_do)
      cnt_nx = cnt + (AW+1)'(1);
    else if (!push_do && pop_do)
      cnt_nx = cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_do) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      head      <= '0;
      rx_en     <= 1'b1;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      rd_ptr <= rd_nx;
      cnt    <= cnt_nx;
      rx_en  <= cnt_nx != FULL_CNT;
      if (push_do) wr_ptr <= wr_ptr + AW'(1);
      // new head may be the entry being written this edge
      if (cnt_nx != '0) begin
        if (push_do && wr_ptr == rd_nx) head <= push_ent;
        else                            head <= mem[rd_nx];
      end
      if (push && !push_do) overflow <= 1'b1;
      if (bad && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  assign evt_valid = cnt != '0;
  assign evt_code  = head[7:0];
  assign evt_ext   = head[8];
  assign evt_break = head[9];

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed cases plus random
// byte streams checked against a queue-based event model.
module tb_ps2_key_sequencer;

  localparam int TMO = 40;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_tick;
  logic       byte_ok;
  logic       rx_en;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       evt_valid;
  logic       evt_pop;
  logic       overflow;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  ps2_key_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .AW         (2),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .byte_in  (byte_in),
    .byte_tick(byte_tick),
    .byte_ok  (byte_ok),
    .rx_en    (rx_en),
    .evt_code (evt_code),
    .evt_break(evt_break),
    .evt_ext  (evt_ext),
    .evt_valid(evt_valid),
    .evt_pop  (evt_pop),
    .overflow (overflow),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: pending prefix flags plus an event queue
  logic [9:0] q[$];
  logic       m_brk, m_ext, m_ovf;
  int         m_idle, m_err;
  logic [9:0] m_head;

  always @(posedge clk) begin : model
    int sz;
    logic full, pd, pu;
    logic [9:0] e;
    if (!rst) begin
      q.delete();
      m_brk = 0; m_ext = 0; m_ovf = 0;
      m_idle = 0; m_err = 0; m_head = '0;
    end else begin
      sz = q.size();
      full = (sz == DEPTH);
      pd = evt_pop && sz > 0;
      pu = 0;
      e = '0;
      if (byte_tick && !byte_ok) begin
        if (m_err < 255) m_err++;
        m_brk = 0; m_ext = 0; m_idle = 0;
      end else if (byte_tick) begin
        m_idle = 0;
        if (byte_in == 8'hE0 || byte_in == 8'hF0) begin
          if (m_brk) begin
            m_brk = 0; m_ext = 0;
          end else if (byte_in == 8'hE0) m_ext = 1;
          else m_brk = 1;
        end else begin
          pu = 1;
          e = {m_brk, m_ext, byte_in};
          m_brk = 0; m_ext = 0;
        end
      end else if (m_brk || m_ext) begin
        if (m_idle == TMO - 1) begin
          m_brk = 0; m_ext = 0; m_idle = 0;
        end else m_idle++;
      end else m_idle = 0;
      if (pd) q.delete(0);
      if (pu) begin
        if (!full || pd) q.push_back(e);
        else m_ovf = 1;
      end
      if (q.size() > 0) m_head = q[0];
    end
  end

  always @(negedge clk) begin : compare
    chk("evt_valid", int'(evt_valid), int'(q.size() > 0));
    chk("rx_en", int'(rx_en), int'(q.size() != DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("err_count", int'(err_count), m_err);
    chk("evt_code", int'(evt_code), int'(m_head[7:0]));
    chk("evt_ext", int'(evt_ext), int'(m_head[8]));
    chk("evt_break", int'(evt_break), int'(m_head[9]));
  end

  task automatic cyc(input logic t, input logic [7:0] b,
                     input logic ok, input logic p);
    byte_tick = t;
    byte_in   = b;
    byte_ok   = ok;
    evt_pop   = p;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 8'h00, 1, 0);
  endtask

  task automatic tk(input logic [7:0] b);
    cyc(1, b, 1, 0);
    cyc(0, 8'h00, 1, 0);
  endtask

  task automatic pop1();
    cyc(0, 8'h00, 1, 1);
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    rst = 0; byte_in = 0; byte_tick = 0; byte_ok = 1; evt_pop = 0;
    repeat (3) @(negedge clk);
    chk("rst_rx_en", int'(rx_en), 1);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_err", int'(err_count), 0);
    rst = 1;
    idle(2);

    cyc(1, 8'h1C, 1, 0);
    chk("t1_valid", int'(evt_valid), 1);
    chk("t1_code", int'(evt_code), 'h1C);
    chk("t1_brk", int'(evt_break), 0);
    pop1();
    chk("t1_empty", int'(evt_valid), 0);

    tk(8'hE0); tk(8'hF0); tk(8'h75);
    chk("t2_code", int'(evt_code), 'h75);
    chk("t2_brk", int'(evt_break), 1);
    chk("t2_ext", int'(evt_ext), 1);
    pop1();
    tk(8'hF0); tk(8'h1C);
    chk("t2b_code", int'(evt_code), 'h1C);
    chk("t2b_brk", int'(evt_break), 1);
    chk("t2b_ext", int'(evt_ext), 0);
    pop1();

    tk(8'hE0); idle(TMO); tk(8'h1C);
    chk("t3_code", int'(evt_code), 'h1C);
    chk("t3_ext", int'(evt_ext), 0);
    pop1();
    chk("t3_single", int'(evt_valid), 0);
    tk(8'hE0); idle(TMO - 3); tk(8'h2A);
    chk("t3b_ext", int'(evt_ext), 1);
    pop1();

    cyc(1, 8'h01, 1, 0); cyc(1, 8'h02, 1, 0);
    cyc(1, 8'h03, 1, 0); cyc(1, 8'h04, 1, 0);
    chk("t4_rx_en", int'(rx_en), 0);
    cyc(1, 8'h05, 1, 0);
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_head", int'(evt_code), 'h01);
    cyc(1, 8'h06, 1, 1);
    chk("t4_head2", int'(evt_code), 'h02);
    chk("t4_full", int'(rx_en), 0);
    drain_exp[0] = 8'h02; drain_exp[1] = 8'h03;
    drain_exp[2] = 8'h04; drain_exp[3] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", int'(evt_code), int'(drain_exp[i]));
      pop1();
    end
    chk("t4_empty", int'(evt_valid), 0);
    chk("t4_rx_en2", int'(rx_en), 1);

    tk(8'hF0);
    cyc(1, 8'h1C, 0, 0);
    chk("t5_err", int'(err_count), 1);
    tk(8'h1C);
    chk("t5_brk", int'(evt_break), 0);
    pop1();
    for (int i = 0; i < 300; i++)
      cyc(1, 8'($urandom), 0, 0);
    chk("t5_sat", int'(err_count), 255);

    tk(8'h1C); tk(8'hE0);
    rst = 0;
    idle(1);
    rst = 1;
    chk("t6_valid", int'(evt_valid), 0);
    chk("t6_rx_en", int'(rx_en), 1);
    chk("t6_ovf", int'(overflow), 0);
    tk(8'h1C);
    chk("t6_code", int'(evt_code), 'h1C);
    chk("t6_ext", int'(evt_ext), 0);
    pop1();

    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      int pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 2) b = 8'hE0;
      else if (pick < 4) b = 8'hF0;
      else b = 8'($urandom);
      if ($urandom_range(0, 199) == 0) idle(TMO + 2);
      if ($urandom_range(0, 499) == 0) begin
        rst = 0;
        idle(1);
        rst = 1;
      end
      cyc($urandom_range(0, 2) == 0, b,
          $urandom_range(0, 9) != 0,
          $urandom_range(0, 3) == 0);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
